// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a single UART transmitter from NUM_REQ byte sources.
// Define UART_TX_ARB_PACKET_LOCK_EN to hold each grant until a byte flagged with req_last_i.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 8
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic [DATA_WIDTH-1:0]         tx_data_o,
    output logic                          tx_write_o,
    input  logic                          tx_buffer_full_i,
    output logic                          busy_o
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]       count_q, count_d;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             valid_g;
    logic             xfer;
    logic             release_now;

    // Search upward from rr_ptr with wrap; first valid requester wins.
    always_comb begin
        int unsigned      cand;
        logic [IDX_W-1:0] cand_idx;
        cand       = 0;
        cand_idx   = '0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand     = (32'(rr_ptr_q) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!pick_found && req_valid_i[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    assign valid_g = req_valid_i[gnt_idx_q];
    assign xfer    = (state_q == GRANT) && valid_g && !tx_buffer_full_i;

`ifdef UART_TX_ARB_PACKET_LOCK_EN
    assign release_now = xfer && req_last_i[gnt_idx_q];
`else
    logic unused_last;
    assign unused_last = ^req_last_i;
    assign release_now = !valid_g || (xfer && ((count_q + 8'd1) == 8'(BURST_LEN)));
`endif

    always_comb begin
        state_d     = state_q;
        gnt_idx_d   = gnt_idx_q;
        rr_ptr_d    = rr_ptr_q;
        count_d     = count_q;
        grant_o     = '0;
        req_ready_o = '0;
        tx_write_o  = 1'b0;
        tx_data_o   = '0;
        busy_o      = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d   = GRANT;
                    gnt_idx_d = pick_idx;
                    count_d   = '0;
                end
            end
            GRANT: begin
                busy_o                 = 1'b1;
                grant_o[gnt_idx_q]     = 1'b1;
                req_ready_o[gnt_idx_q] = !tx_buffer_full_i;
                tx_write_o             = xfer;
                if (xfer) begin
                    tx_data_o = req_data_i[32'(gnt_idx_q)*DATA_WIDTH +: DATA_WIDTH];
`ifdef UART_TX_ARB_PACKET_LOCK_EN
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end
`else
                    count_d = count_q + 8'd1;
`endif
                end
                if (release_now) begin
                    state_d  = IDLE;
                    rr_ptr_d = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            gnt_idx_q <= '0;
            rr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            rr_ptr_q  <= rr_ptr_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected (grantee, byte) pairs are queued
// when a scenario is set up and popped on every tx_write_o pulse.
module tb_uart_tx_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned BL = 8;

    logic            clock_i = 1'b0;
    logic            reset_i = 1'b0;
    logic [NR-1:0]   req_valid_i = '0;
    logic [NR*DW-1:0] req_data_i = '0;
    logic [NR-1:0]   req_last_i = '0;
    logic [NR-1:0]   req_ready_o;
    logic [NR-1:0]   grant_o;
    logic [DW-1:0]   tx_data_o;
    logic            tx_write_o;
    logic            tx_buffer_full_i = 1'b0;
    logic            busy_o;

    always #5 clock_i = ~clock_i;

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .req_valid_i(req_valid_i),
        .req_data_i(req_data_i),
        .req_last_i(req_last_i),
        .req_ready_o(req_ready_o),
        .grant_o(grant_o),
        .tx_data_o(tx_data_o),
        .tx_write_o(tx_write_o),
        .tx_buffer_full_i(tx_buffer_full_i),
        .busy_o(busy_o)
    );

    typedef struct packed {
        logic [NR-1:0] grant;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    int unsigned cnt[NR];
    int unsigned lim[NR];
    int          last_at[NR];
    logic [7:0]  pat[NR][32];

    logic [NR-1:0] s_grant, s_ready;
    logic          s_write, s_busy;
    logic [DW-1:0] s_data;

    // Every write must match the head of the scoreboard.
    always @(negedge clock_i) begin
        if (tx_write_o === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: write data=%h grant=%b, required no write", tx_data_o, grant_o);
            end else begin
                mon_e = exp_q.pop_front();
                if ({grant_o, tx_data_o} !== {mon_e.grant, mon_e.data}) begin
                    bad++;
                    $display("FAIL sb_data: got grant=%b data=%h, required grant=%b data=%h",
                             grant_o, tx_data_o, mon_e.grant, mon_e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_inputs();
        for (int k = 0; k < NR; k++) begin
            req_valid_i[k]         = cnt[k] < lim[k];
            req_data_i[k*DW +: DW] = (cnt[k] < lim[k]) ? pat[k][cnt[k] % 32] : 8'h00;
            req_last_i[k]          = (cnt[k] < lim[k]) && (int'(cnt[k]) == last_at[k]);
        end
    endtask

    task automatic tick();
        logic [NR-1:0] acc;
        @(negedge clock_i);
        s_grant = grant_o;
        s_ready = req_ready_o;
        s_write = tx_write_o;
        s_busy  = busy_o;
        s_data  = tx_data_o;
        acc     = req_valid_i & req_ready_o;
        @(posedge clock_i);
        #1;
        for (int k = 0; k < NR; k++) begin
            if (acc[k] === 1'b1) cnt[k]++;
        end
        drive_inputs();
    endtask

    task automatic setup_clear();
        for (int k = 0; k < NR; k++) begin
            cnt[k]     = 0;
            lim[k]     = 0;
            last_at[k] = -1;
            for (int n = 0; n < 32; n++) pat[k][n] = 8'((k * 37 + n * 11 + 1) & 255);
        end
        tx_buffer_full_i = 1'b0;
        drive_inputs();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    task automatic stop_all();
        for (int k = 0; k < NR; k++) lim[k] = cnt[k];
        drive_inputs();
    endtask

    task automatic push_exp(input int k, input int unsigned from, input int unsigned n);
        exp_t e;
        for (int unsigned i = 0; i < n; i++) begin
            e.grant = NR'(1 << k);
            e.data  = pat[k][(from + i) % 32];
            exp_q.push_back(e);
        end
    endtask

    task automatic check_drained(input string name);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_leftover: %0d expected writes missing, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        setup_clear();
        for (int k = 0; k < NR; k++) lim[k] = 1000;
        last_at[0] = 0;
        reset_i = 1'b1;
        drive_inputs();
        tick();
        tick();
        total++;
        if ({s_busy, s_grant, s_write, s_ready} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl: got busy=%b grant=%b write=%b ready=%b, required all 0",
                     s_busy, s_grant, s_write, s_ready);
        end
        total++;
        if (s_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_data: got %h required 00", s_data);
        end
        reset_i = 1'b0;
        push_exp(0, 0, 1);
        tick();
        total++;
        if ({s_busy, s_grant, s_write} !== 6'b0) begin
            bad++;
            $display("FAIL reset_first_idle: got busy=%b grant=%b write=%b, required 0", s_busy, s_grant, s_write);
        end
        tick();
        total++;
        if ({s_busy, s_grant, s_write} !== {1'b1, 4'b0001, 1'b1}) begin
            bad++;
            $display("FAIL reset_first_grant: got busy=%b grant=%b write=%b, required 1 0001 1",
                     s_busy, s_grant, s_write);
        end
        stop_all();
        tick();
        tick();
        tick();
        check_drained("reset");
    endtask

    task automatic test_round_robin();
        int g;
        setup_clear();
        do_reset();
        for (int k = 0; k < NR; k++) lim[k] = 1000;
        drive_inputs();
        for (int gi = 0; gi < 5; gi++) push_exp(gi % NR, (gi < NR) ? 0 : BL, BL);
        for (int gi = 0; gi < 5; gi++) begin
            g = gi % NR;
            tick();
            total++;
            if ({s_busy, s_grant, s_write} !== 6'b0) begin
                bad++;
                $display("FAIL rr_idle_%0d: got busy=%b grant=%b write=%b, required 0", gi, s_busy, s_grant, s_write);
            end
            for (int b = 0; b < BL; b++) begin
                tick();
                total++;
                if ({s_busy, s_grant, s_write} !== {1'b1, NR'(1 << g), 1'b1}) begin
                    bad++;
                    $display("FAIL rr_grant_%0d_%0d: got busy=%b grant=%b write=%b, required 1 %b 1",
                             gi, b, s_busy, s_grant, s_write, NR'(1 << g));
                end
            end
        end
        stop_all();
        tick();
        tick();
        check_drained("rr");
    endtask

    task automatic test_single_drop();
        setup_clear();
        do_reset();
        pat[2][0] = 8'hA5;
        pat[2][1] = 8'h5A;
        pat[2][2] = 8'hFF;
        lim[2] = 3;
        push_exp(2, 0, 3);
        drive_inputs();
        tick();
        for (int b = 0; b < 3; b++) begin
            tick();
            total++;
            if ({s_grant, s_write} !== {4'b0100, 1'b1}) begin
                bad++;
                $display("FAIL drop_write_%0d: got grant=%b write=%b, required 0100 1", b, s_grant, s_write);
            end
        end
        tick();
        total++;
        if ({s_busy, s_grant, s_write, s_data} !== {1'b1, 4'b0100, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL drop_hold: got busy=%b grant=%b write=%b data=%h, required 1 0100 0 00",
                     s_busy, s_grant, s_write, s_data);
        end
        tick();
        total++;
        if ({s_busy, s_grant} !== 5'b0) begin
            bad++;
            $display("FAIL drop_release: got busy=%b grant=%b, required 0 0000", s_busy, s_grant);
        end
        for (int k = 0; k < NR; k++) lim[k] = cnt[k] + 1;
        push_exp(3, 0, 1);
        drive_inputs();
        tick();
        tick();
        total++;
        if ({s_grant, s_write} !== {4'b1000, 1'b1}) begin
            bad++;
            $display("FAIL drop_rr_next: got grant=%b write=%b, required 1000 1", s_grant, s_write);
        end
        stop_all();
        tick();
        tick();
        tick();
        check_drained("drop");
    endtask

    task automatic test_backpressure();
        setup_clear();
        do_reset();
        lim[0] = 1000;
        push_exp(0, 0, BL);
        drive_inputs();
        tick();
        for (int b = 0; b < 4; b++) tick();
        tx_buffer_full_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if ({s_busy, s_grant, s_write, s_ready} !== {1'b1, 4'b0001, 1'b0, 4'b0000}) begin
                bad++;
                $display("FAIL bp_stall_%0d: got busy=%b grant=%b write=%b ready=%b, required 1 0001 0 0000",
                         c, s_busy, s_grant, s_write, s_ready);
            end
        end
        tx_buffer_full_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            tick();
            total++;
            if ({s_grant, s_write, s_ready} !== {4'b0001, 1'b1, 4'b0001}) begin
                bad++;
                $display("FAIL bp_resume_%0d: got grant=%b write=%b ready=%b, required 0001 1 0001",
                         b, s_grant, s_write, s_ready);
            end
        end
        stop_all();
        tick();
        total++;
        if ({s_busy, s_grant, s_write} !== 6'b0) begin
            bad++;
            $display("FAIL bp_release: got busy=%b grant=%b write=%b, required 0", s_busy, s_grant, s_write);
        end
        check_drained("bp");
    endtask

    task automatic test_reset_abort();
        setup_clear();
        do_reset();
        lim[1] = 1000;
        push_exp(1, 0, 3);
        drive_inputs();
        tick();
        for (int b = 0; b < 3; b++) tick();
        reset_i = 1'b1;
        tx_buffer_full_i = 1'b1;
        tick();
        reset_i = 1'b0;
        tx_buffer_full_i = 1'b0;
        lim[0] = 1;
        push_exp(0, 0, 1);
        drive_inputs();
        tick();
        total++;
        if ({s_busy, s_grant, s_write} !== 6'b0) begin
            bad++;
            $display("FAIL abort_after: got busy=%b grant=%b write=%b, required 0", s_busy, s_grant, s_write);
        end
        tick();
        total++;
        if ({s_grant, s_write} !== {4'b0001, 1'b1}) begin
            bad++;
            $display("FAIL abort_next_grant: got grant=%b write=%b, required 0001 1", s_grant, s_write);
        end
        stop_all();
        tick();
        tick();
        tick();
        check_drained("abort");
    endtask

`ifndef UART_TX_ARB_PACKET_LOCK_EN
    task automatic test_last_ignored();
        setup_clear();
        do_reset();
        lim[3] = 1000;
        last_at[3] = 1;
        push_exp(3, 0, BL);
        drive_inputs();
        tick();
        for (int b = 0; b < BL; b++) tick();
        total++;
        if ({s_grant, s_write} !== {4'b1000, 1'b1}) begin
            bad++;
            $display("FAIL last_ignored_burst: got grant=%b write=%b, required 1000 1", s_grant, s_write);
        end
        stop_all();
        tick();
        total++;
        if ({s_busy, s_grant} !== 5'b0) begin
            bad++;
            $display("FAIL last_ignored_release: got busy=%b grant=%b, required 0", s_busy, s_grant);
        end
        check_drained("last");
    endtask
`else
    task automatic test_packet_lock();
        setup_clear();
        do_reset();
        lim[0] = 20;
        last_at[0] = 19;
        lim[1] = 1000;
        push_exp(0, 0, 20);
        push_exp(1, 0, 1);
        drive_inputs();
        tick();
        for (int b = 0; b < 20; b++) begin
            tick();
            total++;
            if ({s_grant, s_write} !== {4'b0001, 1'b1}) begin
                bad++;
                $display("FAIL lock_write_%0d: got grant=%b write=%b, required 0001 1", b, s_grant, s_write);
            end
        end
        tick();
        total++;
        if ({s_busy, s_grant} !== 5'b0) begin
            bad++;
            $display("FAIL lock_release: got busy=%b grant=%b, required 0", s_busy, s_grant);
        end
        tick();
        total++;
        if ({s_grant, s_write} !== {4'b0010, 1'b1}) begin
            bad++;
            $display("FAIL lock_next: got grant=%b write=%b, required 0010 1", s_grant, s_write);
        end
        stop_all();
        tick();
        tick();
        check_drained("lock");
    endtask
`endif

    initial begin
        test_reset();
`ifndef UART_TX_ARB_PACKET_LOCK_EN
        test_round_robin();
        test_single_drop();
        test_backpressure();
        test_reset_abort();
        test_last_ignored();
`else
        test_packet_lock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
